implication_sequencer: RTL and testbench

IMPLICATION_SEQUENCER -- requirements
Module: implication_sequencer

---
 rtl/implication_sequencer.sv | 129 ++++++++++++
 tb/tb_implication_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/implication_sequencer.sv
`default_nettype none
// implication_sequencer: req/ack burst sequencer with per-transaction retry, abort,
// saturating error counter and sticky violation flag.  Rev 1.0
module implication_sequencer #(
  parameter int CNT_W     = 8,
  parameter int ERR_W     = 8,
  parameter int MAX_RETRY = 3,
  localparam int RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [CNT_W-1:0] num_txn,
  input  logic             ack,
  input  logic             abort,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] txn_idx,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [ERR_W-1:0] err_count,
  output logic             viol
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  localparam logic [RTY_W-1:0] c_max_retry = RTY_W'(MAX_RETRY);
  localparam logic [ERR_W-1:0] c_err_max   = {ERR_W{1'b1}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_txn_idx;
  logic [RTY_W-1:0] r_retry;
  logic [ERR_W-1:0] r_err;
  logic             r_done;
  logic             r_fail;
  logic             r_viol;

  logic             w_unexp_ack;
  logic             w_miss;
  logic             w_err_inc;
  logic [CNT_W-1:0] w_idx_next;

  // An ack outside CHECK is a protocol error; a miss only counts when no abort overrides it.
  assign w_unexp_ack = ack && ((r_state == S_IDLE) || (r_state == S_REQ));
  assign w_miss      = (r_state == S_CHECK) && !abort && !ack;
  assign w_err_inc   = w_unexp_ack || w_miss;
  assign w_idx_next  = r_txn_idx + 1'b1;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_txn_idx <= '0;
      r_retry   <= '0;
      r_err     <= '0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_viol    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_txn != '0) begin
              r_count   <= num_txn;
              r_txn_idx <= '0;
              r_retry   <= '0;
              r_state   <= S_REQ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_fail  <= 1'b1;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_fail  <= 1'b1;
          end else if (ack) begin
            r_txn_idx <= w_idx_next;
            r_retry   <= '0;
            if (w_idx_next == r_count) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_REQ;
            end
          end else if (r_retry < c_max_retry) begin
            r_retry <= r_retry + 1'b1;
            r_state <= S_REQ;
          end else begin
            r_state <= S_IDLE;
            r_fail  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_err_inc && (r_err != c_err_max)) begin
        r_err <= r_err + 1'b1;
      end
      if (w_unexp_ack) begin
        r_viol <= 1'b1;
      end
    end
  end

  assign req       = (r_state == S_REQ);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign fail      = r_fail;
  assign txn_idx   = r_txn_idx;
  assign retry_cnt = r_retry;
  assign err_count = r_err;
  assign viol      = r_viol;

endmodule
`default_nettype wire

// File: tb/tb_implication_sequencer.sv
`default_nettype none
// tb_implication_sequencer: directed and randomized bursts checked against a
// transaction-level model of the sequencer.  Rev 1.0
module tb_implication_sequencer;

  localparam int CNT_W   = 8;
  localparam int ERR_W   = 8;
  localparam int MAXR    = 3;
  localparam int ERR_SAT = 255;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             start;
  logic [CNT_W-1:0] num_txn;
  logic             ack;
  logic             abort;
  logic             req;
  logic             busy;
  logic             done;
  logic             fail;
  logic [CNT_W-1:0] txn_idx;
  logic [1:0]       retry_cnt;
  logic [ERR_W-1:0] err_count;
  logic             viol;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;
  int exp_viol = 0;
  bit acks [0:63];

  implication_sequencer #(.CNT_W(CNT_W), .ERR_W(ERR_W), .MAX_RETRY(MAXR)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .num_txn(num_txn), .ack(ack),
    .abort(abort), .req(req), .busy(busy), .done(done), .fail(fail),
    .txn_idx(txn_idx), .retry_cnt(retry_cnt), .err_count(err_count), .viol(viol)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"},  32'(req),       0);
    chk({tag, ".busy"}, 32'(busy),      0);
    chk({tag, ".done"}, 32'(done),      0);
    chk({tag, ".fail"}, 32'(fail),      0);
    chk({tag, ".idx"},  32'(txn_idx),   0);
    chk({tag, ".rty"},  32'(retry_cnt), 0);
    chk({tag, ".err"},  32'(err_count), 0);
    chk({tag, ".viol"}, 32'(viol),      0);
  endtask

  task automatic fill_acks(input int miss_pct);
    for (int i = 0; i < 64; i++) acks[i] = ($urandom_range(0, 99) >= miss_pct);
  endtask

  // Burst starting in IDLE at cycle 0; acks[k] answers the k-th request.
  // abort_cyc = 0 means no abort; noisy drives spurious start while busy.
  task automatic run_burst(input string tag, input int n, input int abort_cyc, input bit noisy);
    int k = 0, comp = 0, errs = 0, retries = 0, endc = 0;
    bit ok = 0;
    forever begin
      if (abort_cyc != 0 && abort_cyc <= 2 * k + 2) begin
        endc = abort_cyc + 1; ok = 0; break;
      end
      if (acks[k]) begin
        comp++; retries = 0;
        if (comp == n) begin endc = 2 * k + 3; ok = 1; break; end
      end else begin
        errs++;
        if (retries == MAXR) begin endc = 2 * k + 3; ok = 0; break; end
        retries++;
      end
      k++;
    end
    exp_err = (exp_err + errs > ERR_SAT) ? ERR_SAT : exp_err + errs;

    start = 1'b1; num_txn = CNT_W'(n); ack = 1'b0; abort = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= endc + 1; c++) begin
      chk({tag, ".req"},  32'(req),  32'((c % 2 == 1) && (c < endc)));
      chk({tag, ".busy"}, 32'(busy), 32'(c < endc));
      chk({tag, ".done"}, 32'(done), 32'((c == endc) && ok));
      chk({tag, ".fail"}, 32'(fail), 32'((c == endc) && !ok));
      if (c >= endc) begin
        chk({tag, ".idx"},  32'(txn_idx),   32'(comp));
        chk({tag, ".err"},  32'(err_count), 32'(exp_err));
        chk({tag, ".viol"}, 32'(viol),      32'(exp_viol));
        if (ok) chk({tag, ".rty"}, 32'(retry_cnt), 0);
      end
      ack   = 1'b0;
      abort = 1'b0;
      if (c % 2 == 0 && c < endc) ack = (c == abort_cyc) ? 1'b1 : acks[c / 2 - 1];
      if (c == abort_cyc && c < endc) abort = 1'b1;
      start   = noisy && (c < endc) && ($urandom_range(0, 1) == 1);
      num_txn = CNT_W'($urandom);
      tick();
    end
    start = 1'b0; ack = 1'b0; abort = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; start = 1'b0; num_txn = '0; ack = 1'b0; abort = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    RESET = 1'b1;

    fill_acks(0);
    run_burst("three_ok", 3, 0, 0);

    for (int i = 0; i < 64; i++) acks[i] = 1'b0;
    run_burst("no_ack", 1, 0, 0);

    fill_acks(0); acks[0] = 1'b0;
    run_burst("one_retry", 1, 0, 0);

    fill_acks(0);
    run_burst("abort_chk", 2, 2, 0);
    fill_acks(0);
    run_burst("abort_req", 3, 3, 0);

    // Spurious ack in IDLE, then zero-length burst, then reset clears all.
    ack = 1'b1; tick(); ack = 1'b0;
    exp_err++; exp_viol = 1;
    chk("idle_ack.viol", 32'(viol), 1);
    chk("idle_ack.err",  32'(err_count), 32'(exp_err));
    chk("idle_ack.busy", 32'(busy), 0);
    start = 1'b1; num_txn = '0; tick(); start = 1'b0;
    chk("zero.done", 32'(done), 1);
    chk("zero.req",  32'(req),  0);
    chk("zero.busy", 32'(busy), 0);
    chk("zero.fail", 32'(fail), 0);
    tick();
    chk("zero.done_end", 32'(done), 0);
    RESET = 1'b0; tick(); RESET = 1'b1;
    exp_err = 0; exp_viol = 0;
    chk_all_zero("reset_idle");

    // Reset mid-burst, with active inputs held during reset.
    start = 1'b1; num_txn = 8'd4; tick(); start = 1'b0;
    tick(); tick();
    chk("mid.busy", 32'(busy), 1);
    RESET = 1'b0; start = 1'b1; ack = 1'b1; abort = 1'b1; num_txn = 8'd5;
    tick();
    chk_all_zero("mid_rst");
    tick();
    chk_all_zero("held_rst");
    RESET = 1'b1; start = 1'b0; ack = 1'b0; abort = 1'b0;
    fill_acks(0);
    run_burst("post_rst", 2, 0, 0);

    for (int r = 0; r < 25; r++) begin
      int n  = int'($urandom_range(1, 6));
      int ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * n)) : 0;
      fill_acks(30);
      run_burst("rand", n, ac, 1'b1);
    end

    for (int i = 0; i < 64; i++) acks[i] = 1'b0;
    while (exp_err < ERR_SAT) run_burst("sat_fill", 1, 0, 0);
    run_burst("sat_hold", 1, 0, 0);
    chk("sat.err", 32'(err_count), ERR_SAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
